// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction-fetch unit.
package ifu_pkg;
    localparam int          XLEN_DEF     = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;
    localparam logic [1:0]  ALIGN_MASK   = 2'b11;

    typedef enum logic [2:0] {
        S_REQ,
        S_WAIT,
        S_OUT,
        S_NEXT,
        S_ERR
    } state_t;

    function automatic logic addr_aligned(input logic [1:0] lsb);
        return (lsb & ALIGN_MASK) == 2'b00;
    endfunction
endpackage

// File: rtl/ifu_pc_reg.sv
// Architectural PC register with synchronous reset, load enable and
// an alignment check on the candidate load value.
module ifu_pc_reg
    import ifu_pkg::*;
#(
    parameter int               XLEN     = XLEN_DEF,
    parameter logic [XLEN-1:0]  RESET_PC = RESET_PC_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ld_en,
    input  logic [XLEN-1:0] ld_pc,
    output logic            ld_pc_ok,
    output logic [XLEN-1:0] pc
);
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (ld_en) begin
            pc_d = ld_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign ld_pc_ok = addr_aligned(ld_pc[1:0]);
    assign pc       = pc_q;
endmodule

// File: rtl/ifu_fetch.sv
// Single-outstanding instruction fetch: request, wait response, hand to decode,
// then wait for the next PC. Faults park the unit in S_ERR until reset.
module ifu_fetch
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
    parameter int          XLEN      = XLEN_DEF,
    parameter logic [31:0] CNT_RESET = 32'h0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] next_pc,
    input  logic            next_pc_valid,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    output logic            imem_rsp_ready,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            imem_rsp_err,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    output logic            fetch_err,
    output logic [XLEN-1:0] err_pc,
    output logic [31:0]     fetch_cnt
);
    state_t          state_q, state_d;
    logic [XLEN-1:0] inst_q, inst_d;
    logic [XLEN-1:0] inst_pc_q, inst_pc_d;
    logic            err_q, err_d;
    logic [XLEN-1:0] err_pc_q, err_pc_d;
    logic [31:0]     cnt_q, cnt_d;
    logic [XLEN-1:0] pc;
    logic            npc_ok;
    logic            pc_ld;

    ifu_pc_reg #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC[XLEN-1:0])
    ) u_pc_reg (
        .clk      (clk),
        .rst      (rst),
        .ld_en    (pc_ld),
        .ld_pc    (next_pc),
        .ld_pc_ok (npc_ok),
        .pc       (pc)
    );

    // A misaligned next_pc is never loaded; pc keeps the last good value.
    assign pc_ld = (state_q == S_NEXT) && next_pc_valid && npc_ok;

    always_comb begin
        state_d   = state_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        err_d     = err_q;
        err_pc_d  = err_pc_q;
        cnt_d     = cnt_q;
        case (state_q)
            S_REQ: begin
                if (imem_req_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    if (imem_rsp_err) begin
                        err_d    = 1'b1;
                        err_pc_d = pc;
                        state_d  = S_ERR;
                    end else begin
                        inst_d    = imem_rsp_data;
                        inst_pc_d = pc;
                        state_d   = S_OUT;
                    end
                end
            end
            S_OUT: begin
                if (inst_ready) begin
                    cnt_d   = cnt_q + 32'd1;
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                if (next_pc_valid) begin
                    if (npc_ok) begin
                        state_d = S_REQ;
                    end else begin
                        err_d    = 1'b1;
                        err_pc_d = next_pc;
                        state_d  = S_ERR;
                    end
                end
            end
            default: state_d = S_ERR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_REQ;
            inst_q    <= '0;
            inst_pc_q <= '0;
            err_q     <= 1'b0;
            err_pc_q  <= '0;
            cnt_q     <= CNT_RESET;
        end else begin
            state_q   <= state_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
            err_q     <= err_d;
            err_pc_q  <= err_pc_d;
            cnt_q     <= cnt_d;
        end
    end

    // Handshake outputs are forced low while reset is held.
    assign imem_req_valid = !rst && (state_q == S_REQ);
    assign imem_rsp_ready = !rst && (state_q == S_WAIT);
    assign inst_valid     = !rst && (state_q == S_OUT);
    assign imem_req_addr  = pc;
    assign inst           = inst_q;
    assign inst_pc        = inst_pc_q;
    assign fetch_err      = err_q;
    assign err_pc         = err_pc_q;
    assign fetch_cnt      = cnt_q;
endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch; a second instance starts its counter near wrap.
module tb_ifu_fetch;
    localparam logic [31:0] RPC   = 32'h8000_0000;
    localparam logic [31:0] CNT2  = 32'hFFFF_FFFE;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] next_pc;
    logic        next_pc_valid;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        inst_ready;

    logic        imem_req_valid, imem_rsp_ready, inst_valid, fetch_err;
    logic [31:0] imem_req_addr, inst, inst_pc, err_pc, fetch_cnt;
    logic        d2_req_valid, d2_rsp_ready, d2_inst_valid, d2_fetch_err;
    logic [31:0] d2_req_addr, d2_inst, d2_inst_pc, d2_err_pc, d2_fetch_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    int req_acc = 0;
    logic [31:0] exp_cnt;

    always #5 clk = ~clk;

    ifu_fetch #(.RESET_PC(RPC), .XLEN(32)) dut (
        .clk(clk), .rst(rst), .next_pc(next_pc), .next_pc_valid(next_pc_valid),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_ready(imem_rsp_ready), .imem_rsp_data(imem_rsp_data),
        .imem_rsp_err(imem_rsp_err), .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst(inst), .inst_pc(inst_pc), .fetch_err(fetch_err), .err_pc(err_pc),
        .fetch_cnt(fetch_cnt)
    );

    ifu_fetch #(.RESET_PC(RPC), .XLEN(32), .CNT_RESET(CNT2)) dut_wrap (
        .clk(clk), .rst(rst), .next_pc(next_pc), .next_pc_valid(next_pc_valid),
        .imem_req_valid(d2_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(d2_req_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_ready(d2_rsp_ready), .imem_rsp_data(imem_rsp_data),
        .imem_rsp_err(imem_rsp_err), .inst_valid(d2_inst_valid), .inst_ready(inst_ready),
        .inst(d2_inst), .inst_pc(d2_inst_pc), .fetch_err(d2_fetch_err), .err_pc(d2_err_pc),
        .fetch_cnt(d2_fetch_cnt)
    );

    always @(posedge clk) begin
        if (!rst && imem_req_valid && imem_req_ready) req_acc <= req_acc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic fetch(input logic [31:0] a, input int stall,
                         input logic [31:0] d, input logic e);
        int n = 0;
        while (!imem_req_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("req_vld", {31'b0, imem_req_valid}, 32'd1);
        chk("req_addr", imem_req_addr, a);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk("stall_vld", {31'b0, imem_req_valid}, 32'd1);
            chk("stall_addr", imem_req_addr, a);
        end
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        chk("rsp_rdy", {31'b0, imem_rsp_ready}, 32'd1);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = d;
        imem_rsp_err   = e;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        imem_rsp_err   = 1'b0;
    endtask

    task automatic deliver(input logic [31:0] pc, input logic [31:0] d);
        chk("inst_vld", {31'b0, inst_valid}, 32'd1);
        chk("inst", inst, d);
        chk("inst_pc", inst_pc, pc);
        inst_ready = 1'b1;
        @(negedge clk);
        inst_ready = 1'b0;
        exp_cnt = exp_cnt + 32'd1;
        chk("fetch_cnt", fetch_cnt, exp_cnt);
        chk("wrap_cnt", d2_fetch_cnt, CNT2 + exp_cnt);
        chk("inst_vld_drop", {31'b0, inst_valid}, 32'd0);
    endtask

    task automatic npc(input logic [31:0] v);
        next_pc       = v;
        next_pc_valid = 1'b1;
        @(negedge clk);
        next_pc_valid = 1'b0;
    endtask

    initial begin
        int acc0;
        rst = 1'b1; next_pc = '0; next_pc_valid = 1'b0; imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0; imem_rsp_data = '0; imem_rsp_err = 1'b0; inst_ready = 1'b0;
        exp_cnt = '0;
        repeat (2) @(negedge clk);
        chk("rst_req_vld", {31'b0, imem_req_valid}, 32'd0);
        chk("rst_rsp_rdy", {31'b0, imem_rsp_ready}, 32'd0);
        chk("rst_inst_vld", {31'b0, inst_valid}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_cnt", fetch_cnt, 32'd0);
        chk("rst_wrap_cnt", d2_fetch_cnt, CNT2);
        chk("rst_inst", inst, 32'd0);
        chk("rst_inst_pc", inst_pc, 32'd0);
        chk("rst_err", {31'b0, fetch_err}, 32'd0);
        chk("rst_err_pc", err_pc, 32'd0);

        // First fetch, stray next_pc pulse while holding the instruction.
        fetch(RPC, 0, 32'h0000_0013, 1'b0);
        npc(32'h8000_0100);
        chk("out_hold_vld", {31'b0, inst_valid}, 32'd1);
        deliver(RPC, 32'h0000_0013);
        chk("next_req_vld", {31'b0, imem_req_valid}, 32'd0);
        chk("next_pc_hold", imem_req_addr, RPC);
        npc(32'h8000_0004);

        acc0 = req_acc;
        fetch(32'h8000_0004, 5, 32'h0010_0093, 1'b0);
        chk("one_accept", req_acc - acc0, 32'd1);
        deliver(32'h8000_0004, 32'h0010_0093);
        npc(32'h8000_0010);
        fetch(32'h8000_0010, 0, 32'h0020_8113, 1'b0);
        deliver(32'h8000_0010, 32'h0020_8113);

        // Access fault on the response.
        npc(32'h8000_0008);
        fetch(32'h8000_0008, 0, 32'hDEAD_BEEF, 1'b1);
        chk("rsp_err", {31'b0, fetch_err}, 32'd1);
        chk("rsp_err_pc", err_pc, 32'h8000_0008);
        npc(32'h8000_0000);
        for (int i = 0; i < 3; i++) begin
            chk("err_inst_vld", {31'b0, inst_valid}, 32'd0);
            chk("err_req_vld", {31'b0, imem_req_valid}, 32'd0);
            @(negedge clk);
        end

        // Reset with a request outstanding, then a stale response.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_cnt = '0;
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        chk("wait_rsp_rdy", {31'b0, imem_rsp_ready}, 32'd1);
        rst = 1'b1;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hBAD0_0BAD;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("stale_rsp_rdy", {31'b0, imem_rsp_ready}, 32'd0);
        imem_rsp_valid = 1'b0;
        chk("stale_inst_vld", {31'b0, inst_valid}, 32'd0);
        chk("stale_inst", inst, 32'd0);
        chk("stale_err", {31'b0, fetch_err}, 32'd0);
        chk("stale_cnt", fetch_cnt, 32'd0);

        // Misaligned next_pc.
        fetch(RPC, 0, 32'h0000_006F, 1'b0);
        deliver(RPC, 32'h0000_006F);
        npc(32'h8000_0006);
        chk("mis_err", {31'b0, fetch_err}, 32'd1);
        chk("mis_err_pc", err_pc, 32'h8000_0006);
        chk("mis_pc_kept", imem_req_addr, RPC);
        for (int i = 0; i < 3; i++) begin
            chk("mis_req_vld", {31'b0, imem_req_valid}, 32'd0);
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction-fetch unit: owns the architectural PC register and issues one instruction fetch at a time to instruction memory over a valid/ready request/response pair.
- Hands the fetched instruction and its PC to decode, then waits for the execute stage's next-PC result before fetching again.
- It is the consumer of the next-PC selection logic: it takes the computed next_pc and turns it into the PC update and the memory request.
- Targets the multi-cycle (non-pipelined) NPC core: exactly one instruction is in flight.

Parameters:
- RESET_PC, 32'h8000_0000, PC loaded on reset; first fetch address.
- XLEN, 32, address/data width.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous active-high reset.
- next_pc  in  XLEN  PC from next-PC logic.
- next_pc_valid  in  1  one-cycle pulse; next_pc is valid.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  XLEN  fetch address (= pc).
- imem_rsp_valid  in  1  response valid.
- imem_rsp_ready  out  1  IFU accepts response.
- imem_rsp_data  in  XLEN  instruction word.
- imem_rsp_err  in  1  access fault with response.
- inst_valid  out  1  instruction to decode valid.
- inst_ready  in  1  decode accepts.
- inst  out  XLEN  held instruction.
- inst_pc  out  XLEN  PC of inst.
- fetch_err  out  1  sticky fault flag.
- err_pc  out  XLEN  PC of faulting fetch or rejected next_pc.
- fetch_cnt  out  32  count of instructions delivered to decode.

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - pc=RESET_PC, state=S_REQ, inst=0, inst_pc=0, fetch_err=0, err_pc=0, fetch_cnt=0.
  - All valid/ready outputs are 0 during the reset cycle.
  - Reset in any state (including S_WAIT with a request outstanding) abandons that transaction.
- States: S_REQ, S_WAIT, S_OUT, S_NEXT, S_ERR. Outputs are Moore-decoded from state.
- S_REQ: imem_req_valid=1, imem_req_addr=pc; address held stable until imem_req_ready. On imem_req_valid & imem_req_ready, go to S_WAIT. Request-to-response minimum latency is 1 cycle.
- S_WAIT: imem_rsp_ready=1. On imem_rsp_valid:
  - if imem_rsp_err=1: fetch_err<=1, err_pc<=pc, go to S_ERR.
  - else: inst<=imem_rsp_data, inst_pc<=pc, go to S_OUT.
- Responses arriving in any state other than S_WAIT are ignored; imem_rsp_ready=0 there.
- S_OUT: inst_valid=1; inst and inst_pc are held stable. On inst_ready, fetch_cnt<=fetch_cnt+1 (wraps from 2^32-1 to 0), go to S_NEXT.
- S_NEXT: wait for next_pc_valid.
  - If next_pc[1:0]==0: pc<=next_pc, go to S_REQ.
  - Else: fetch_err<=1, err_pc<=next_pc, pc unchanged, go to S_ERR.
  - next_pc_valid pulses in any other state are ignored.
- S_ERR: absorbing; no requests issued. Only rst exits.
- A self-loop next_pc==pc (e.g. a halt loop) is legal: the same address is refetched indefinitely.
- Throughput: at best 4 cycles per instruction (REQ, WAIT, OUT, NEXT) with zero-wait memory, decode and next-PC.

Decomposition:
- Shared package ifu_pkg: state enum (S_REQ, S_WAIT, S_OUT, S_NEXT, S_ERR), XLEN, RESET_PC default, alignment-mask constant.
- One natural sub-module, ifu_pc_reg: holds pc with synchronous reset to RESET_PC, load enable, and the alignment check.
- The FSM and output registers stay in ifu_fetch.

Test Plan:
- Reset, zero-wait memory returning 32'h00000013: imem_req_addr=32'h8000_0000 on the first post-reset cycle; inst=32'h00000013, inst_pc=32'h8000_0000 two cycles later; fetch_cnt=1 after inst_ready.
- imem_req_ready held low for 5 cycles: imem_req_valid and imem_req_addr stay constant throughout; exactly one request is accepted.
- Sequence next_pc=32'h8000_0004, then 32'h8000_0010 (jump): the next two requests go to those addresses; inst_pc matches each.
- next_pc=32'h8000_0006: fetch_err=1, err_pc=32'h8000_0006, no further imem_req_valid.
- imem_rsp_err=1 on a fetch at 32'h8000_0008: fetch_err=1, err_pc=32'h8000_0008, inst_valid never asserts.
- rst asserted in S_WAIT, then a stale response: the response is ignored, and the next request goes to RESET_PC.
- next_pc_valid pulsed during S_OUT: ignored; pc is unchanged.
- fetch_cnt preloaded near 32'hFFFF_FFFF: it wraps to 0.
